// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture block: capture FSM states,
// default frame geometry and the RGB565 -> RGB444 reduction.
package cam_pkg;

    localparam int H_PIXELS_DEF = 320;
    localparam int V_LINES_DEF  = 240;

    typedef enum logic [2:0] {
        WAIT_VS_HIGH,
        WAIT_VS_LOW,
        LINE_IDLE,
        BYTE_HI,
        BYTE_LO
    } cam_state_t;

    // Keep the top bits of each colour channel: {R[4:1], G[5:2], B[4:1]}.
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// Brings the camera pixel bus into the clk_in domain. pclk gets a third
// flop so a rising edge can be detected; vsync, href and data stop at the
// second stage so they line up with the cycle the edge is reported in.
module cam_sync #(
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              pclk_i,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              pclk_edge_o,
    output logic              vsync_o,
    output logic              href_o,
    output logic [DATA_W-1:0] data_o
);

    logic [2:0]        pclk_q;
    logic [1:0]        vsync_q;
    logic [1:0]        href_q;
    logic [DATA_W-1:0] data1_q;
    logic [DATA_W-1:0] data2_q;

    // Strobe synchronisers; cleared on reset so no phantom edge or vsync appears.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pclk_q  <= '0;
            vsync_q <= '0;
            href_q  <= '0;
        end else begin
            pclk_q  <= {pclk_q[1:0], pclk_i};
            vsync_q <= {vsync_q[0], vsync_i};
            href_q  <= {href_q[0], href_i};
        end
    end

    // Data bus delayed by the same two stages as the strobes.
    always_ff @(posedge clk_in) begin
        data1_q <= data_i;
        data2_q <= data1_q;
    end

    assign pclk_edge_o = pclk_q[1] & ~pclk_q[2];
    assign vsync_o     = vsync_q[1];
    assign href_o      = href_q[1];
    assign data_o      = data2_q;

endmodule

// File: rtl/camera_capture.sv
// Camera pixel bus receiver: pairs bytes into RGB565 pixels, reduces them to
// RGB444 and tags each with column, row and a linear frame-buffer address.
module camera_capture
    import cam_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int ADDR_W   = 17
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        cam_pclk_in,
    input  logic                        cam_vsync_in,
    input  logic                        cam_href_in,
    input  logic [7:0]                  cam_data_in,
    output logic [11:0]                 pixel_out,
    output logic                        pixel_valid_out,
    output logic [$clog2(H_PIXELS)-1:0] hcount_out,
    output logic [$clog2(V_LINES)-1:0]  vcount_out,
    output logic [ADDR_W-1:0]           addr_out,
    output logic                        frame_done_out,
    output logic                        line_err_out
);

    localparam int HC_W  = $clog2(H_PIXELS);
    localparam int VC_W  = $clog2(V_LINES);
    // Internal counters need to hold the saturation values themselves.
    localparam int HCI_W = $clog2(H_PIXELS + 1);
    localparam int VCI_W = $clog2(V_LINES + 1);
    localparam logic [HCI_W-1:0]  H_MAX  = HCI_W'(H_PIXELS);
    localparam logic [VCI_W-1:0]  V_MAX  = VCI_W'(V_LINES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

    logic       edge_s, vsync_s, href_s;
    logic [7:0] data_s;

    cam_sync #(.DATA_W(8)) u_sync (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .pclk_i      (cam_pclk_in),
        .vsync_i     (cam_vsync_in),
        .href_i      (cam_href_in),
        .data_i      (cam_data_in),
        .pclk_edge_o (edge_s),
        .vsync_o     (vsync_s),
        .href_o      (href_s),
        .data_o      (data_s)
    );

    cam_state_t        state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [HCI_W-1:0]  hcnt_q, hcnt_d;
    logic [VCI_W-1:0]  vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [11:0]       pix_q, pix_d;
    logic              pvld_q, pvld_d;
    logic [HC_W-1:0]   hco_q, hco_d;
    logic [VC_W-1:0]   vco_q, vco_d;
    logic [ADDR_W-1:0] ao_q, ao_d;
    logic              fdone_q, fdone_d;
    logic              lerr_q, lerr_d;
    logic              in_line;

    // Next-state and output decode; vsync beats line end, line end beats a byte.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        addr_d  = addr_q;
        base_d  = base_q;
        pix_d   = pix_q;
        pvld_d  = 1'b0;
        hco_d   = hco_q;
        vco_d   = vco_q;
        ao_d    = ao_q;
        fdone_d = 1'b0;
        lerr_d  = 1'b0;
        in_line = (state_q == BYTE_HI) || (state_q == BYTE_LO);

        case (state_q)
            WAIT_VS_HIGH: begin
                if (vsync_s) state_d = WAIT_VS_LOW;
            end
            WAIT_VS_LOW: begin
                if (!vsync_s) begin
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                    addr_d  = '0;
                    base_d  = '0;
                    state_d = LINE_IDLE;
                end
            end
            LINE_IDLE, BYTE_HI, BYTE_LO: begin
                if (vsync_s) begin
                    // An aborted line still closes the frame it belonged to.
                    fdone_d = (vcnt_q != '0) || in_line;
                    lerr_d  = in_line;
                    state_d = WAIT_VS_LOW;
                end else if (in_line && !href_s) begin
                    // Odd byte count or short line: a single error pulse either way.
                    lerr_d  = (state_q == BYTE_LO) || ((hcnt_q != '0) && (hcnt_q < H_MAX));
                    hcnt_d  = '0;
                    if (vcnt_q < V_MAX) begin
                        vcnt_d = vcnt_q + VCI_W'(1);
                        base_d = base_q + H_STEP;
                        // Realign from the line base so a short line cannot skew addresses.
                        addr_d = base_q + H_STEP;
                    end
                    state_d = LINE_IDLE;
                end else if (edge_s && href_s) begin
                    if (state_q == BYTE_LO) begin
                        if ((hcnt_q < H_MAX) && (vcnt_q < V_MAX)) begin
                            pvld_d = 1'b1;
                            pix_d  = rgb565_to_444({hi_q, data_s});
                            hco_d  = hcnt_q[HC_W-1:0];
                            vco_d  = vcnt_q[VC_W-1:0];
                            ao_d   = addr_q;
                            hcnt_d = hcnt_q + HCI_W'(1);
                            addr_d = addr_q + ADDR_W'(1);
                        end
                        state_d = BYTE_HI;
                    end else begin
                        hi_d    = data_s;
                        state_d = BYTE_LO;
                    end
                end
            end
            default: state_d = WAIT_VS_HIGH;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= WAIT_VS_HIGH;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            addr_q  <= '0;
            base_q  <= '0;
            pix_q   <= '0;
            pvld_q  <= 1'b0;
            hco_q   <= '0;
            vco_q   <= '0;
            ao_q    <= '0;
            fdone_q <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            pix_q   <= pix_d;
            pvld_q  <= pvld_d;
            hco_q   <= hco_d;
            vco_q   <= vco_d;
            ao_q    <= ao_d;
            fdone_q <= fdone_d;
            lerr_q  <= lerr_d;
        end
    end

    // High byte holding register; its content is irrelevant until a new byte lands.
    always_ff @(posedge clk_in) begin
        hi_q <= hi_d;
    end

    assign pixel_out       = pix_q;
    assign pixel_valid_out = pvld_q;
    assign hcount_out      = hco_q;
    assign vcount_out      = vco_q;
    assign addr_out        = ao_q;
    assign frame_done_out  = fdone_q;
    assign line_err_out    = lerr_q;

endmodule
